conv_word_serializer: RTL

//  Parametrised successor to the convolution-output splitter. Accepts one wide

---
 rtl/conv_word_serializer_pkg.sv | 13 +
 rtl/conv_word_serializer_mux.sv | 24 ++
 rtl/conv_word_serializer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/conv_word_serializer_pkg.sv
// Shared definitions for the convolution-output word serializer.
package conv_word_serializer_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int CONV_WORD_W    = 32;
  localparam int CONV_NUM_WORDS = 9;
  localparam int CONV_IDX_W     = $clog2(CONV_NUM_WORDS);

endpackage

// File: rtl/conv_word_serializer_mux.sv
// NUM_WORDS:1 word select by emission index; ordering chosen by MSW_FIRST.
module conv_word_mux
  import conv_word_serializer_pkg::*;
#(
  parameter int WORD_W    = CONV_WORD_W,
  parameter int NUM_WORDS = CONV_NUM_WORDS,
  parameter int MSW_FIRST = 1,
  parameter int IDX_W     = $clog2(NUM_WORDS)
) (
  input  logic [NUM_WORDS*WORD_W-1:0] vec_i,
  input  logic [IDX_W-1:0]            idx_i,
  output logic [WORD_W-1:0]           word_o
);

  always_comb begin
    word_o = '0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      if (idx_i == IDX_W'(k)) begin
        word_o = vec_i[((MSW_FIRST != 0) ? (NUM_WORDS - 1 - k) : k) * WORD_W +: WORD_W];
      end
    end
  end

endmodule

// File: rtl/conv_word_serializer.sv
// Wide-vector to word-stream serializer with an active buffer and one staging
// buffer so the next vector can be taken while the current one drains.
module conv_word_serializer
  import conv_word_serializer_pkg::*;
#(
  parameter  int WORD_W    = CONV_WORD_W,
  parameter  int NUM_WORDS = CONV_NUM_WORDS,
  parameter  int MSW_FIRST = 1,
  localparam int IDX_W     = $clog2(NUM_WORDS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_WORDS*WORD_W-1:0] in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [WORD_W-1:0]           out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_last,
  output logic [IDX_W-1:0]            out_idx,
  output logic                        busy,
  output state_t                      state_dbg
);

  localparam int VEC_W = NUM_WORDS * WORD_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; a producer holding valid keeps its payload stable until then.

  state_t             state_q;
  logic [VEC_W-1:0]   active_q;
  logic [VEC_W-1:0]   stage_q;
  logic               stage_full_q;
  logic               init_q;
  logic [WORD_W-1:0]  out_data_q;
  logic               out_valid_q;
  logic               out_last_q;
  logic [IDX_W-1:0]   idx_q;

  logic               in_xfer;
  logic               out_xfer;
  logic               last_xfer;
  logic               advance;
  logic               slot_free;
  logic               load;
  logic               stage_wr;
  logic [VEC_W-1:0]   load_vec;
  logic [VEC_W-1:0]   mux_vec;
  logic [IDX_W-1:0]   mux_idx;
  logic [WORD_W-1:0]  mux_word;

  always_comb begin
    in_xfer   = in_valid & in_ready;
    out_xfer  = out_valid_q & out_ready;
    last_xfer = out_xfer & out_last_q;
    advance   = out_xfer & ~out_last_q;
    // Active buffer may be (re)loaded this edge: idle, or its final word leaves now.
    slot_free = (state_q == ST_EMPTY) | last_xfer;
    load      = slot_free & (stage_full_q | in_xfer);
    load_vec  = stage_full_q ? stage_q : in_data;
    // Incoming vector bypasses staging only when it goes straight to active.
    stage_wr  = in_xfer & ~(slot_free & ~stage_full_q);
    mux_vec   = load ? load_vec : active_q;
    mux_idx   = load ? '0 : idx_q + IDX_W'(1);
  end

  conv_word_mux #(
    .WORD_W   (WORD_W),
    .NUM_WORDS(NUM_WORDS),
    .MSW_FIRST(MSW_FIRST),
    .IDX_W    (IDX_W)
  ) u_mux (
    .vec_i (mux_vec),
    .idx_i (mux_idx),
    .word_o(mux_word)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_EMPTY;
      active_q     <= '0;
      stage_q      <= '0;
      stage_full_q <= 1'b0;
      init_q       <= 1'b0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      idx_q        <= '0;
    end else begin
      init_q <= 1'b1;
      if (stage_wr) begin
        stage_q      <= in_data;
        stage_full_q <= 1'b1;
      end else if (load && stage_full_q) begin
        stage_full_q <= 1'b0;
      end

      if (load) begin
        active_q <= load_vec;
      end
      if (load || advance) begin
        out_data_q  <= mux_word;
        idx_q       <= mux_idx;
        out_last_q  <= (mux_idx == LAST_IDX);
        out_valid_q <= 1'b1;
      end

      case (state_q)
        ST_EMPTY: begin
          if (load) state_q <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (last_xfer && !load) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
          end
        end
        default: state_q <= ST_EMPTY;
      endcase
    end
  end

  assign in_ready  = init_q & ~stage_full_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_idx   = idx_q;
  assign busy      = (state_q == ST_SHIFT) | stage_full_q;
  assign state_dbg = state_q;

endmodule
